k052109_video_timing: RTL

- Raster timing generator for the k052109 tilemap model.
- Built as the upstream stage of the tile fetch/shift logic: a pixel-enable divider, a 9-bit horizontal counter and a 9-bit vertical counter, modelled on C43-style synchronous counters.
- Produces the registered blank, sync and vertical-blank interrupt signals that the tile address generator and the k051962 pixel path consume.

---
 rtl/k052109_video_timing.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/k052109_video_timing.sv
// k052109 raster timing: pixel divider, H/V counters, blank/sync decodes, vblank IRQ.
// Define CELL_DLY_EN to give every flop output its library worst-case cell delay.
`timescale 1ns/1ps

`ifdef CELL_DLY_EN
`define K52_DC #8.37
`define K52_DF #5.96
`define K52_DR #5.54
`else
`define K52_DC
`define K52_DF
`define K52_DR
`endif

module k052109_video_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 384,
  parameter int H_ACT    = 288,
  parameter int HS_START = 304,
  parameter int HS_END   = 336,
  parameter int V_TOTAL  = 264,
  parameter int V_ACT    = 224,
  parameter int VS_START = 240,
  parameter int VS_END   = 248
) (
  input  logic       CK,
  input  logic       CLn,
  input  logic       IRQ_EN,
  input  logic       IRQ_ACKn,
  output logic       PE,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLKn,
  output logic       VBLKn,
  output logic       HSYNCn,
  output logic       VSYNCn,
  output logic       IRQn,
  output logic       FIELD
);

  if (CLK_DIV < 2 || CLK_DIV > 8) begin : g_bad_div
    $error("k052109_video_timing: CLK_DIV out of range 2..8");
  end
  if (!(H_ACT < HS_START && HS_START < HS_END &&
        HS_END <= H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h
    $error("k052109_video_timing: illegal horizontal geometry");
  end
  if (!(V_ACT < VS_START && VS_START < VS_END &&
        VS_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v
    $error("k052109_video_timing: illegal vertical geometry");
  end

  localparam logic [2:0] DIV_MAX = 3'(CLK_DIV - 1);
  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_PRE   = 9'(V_ACT - 1);
  localparam logic [9:0] HA  = 10'(H_ACT);
  localparam logic [9:0] HSS = 10'(HS_START);
  localparam logic [9:0] HSE = 10'(HS_END);
  localparam logic [9:0] VA  = 10'(V_ACT);
  localparam logic [9:0] VSS = 10'(VS_START);
  localparam logic [9:0] VSE = 10'(VS_END);

  logic [2:0] div;
  logic [8:0] hnx;
  logic [8:0] vnx;
  logic       fnx;
  logic       irq_set;
  logic       irq_clr;

  always_comb begin
    hnx = HCNT;
    vnx = VCNT;
    fnx = FIELD;
    if (PE) begin
      if (HCNT == H_LAST) begin
        hnx = '0;
        if (VCNT == V_LAST) begin
          vnx = '0;
          fnx = ~FIELD;
        end else begin
          vnx = VCNT + 9'd1;
        end
      end else begin
        hnx = HCNT + 9'd1;
      end
    end
  end

  // set fires on the pixel edge that enters line V_ACT at HCNT 0
  assign irq_set = PE && IRQ_EN && HCNT == H_LAST && VCNT == V_PRE;
  assign irq_clr = !IRQ_ACKn || !IRQ_EN;

  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) begin
      div <= `K52_DR '0;
      PE  <= `K52_DR 1'b0;
    end else begin
      PE  <= `K52_DC (div == DIV_MAX);
      div <= `K52_DC (div == DIV_MAX) ? 3'd0 : div + 3'd1;
    end
  end

  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) begin
      HCNT  <= `K52_DR '0;
      VCNT  <= `K52_DR '0;
      FIELD <= `K52_DR 1'b0;
    end else if (PE) begin
      HCNT  <= `K52_DC hnx;
      VCNT  <= `K52_DC vnx;
      FIELD <= `K52_DC fnx;
    end
  end

  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) begin
      HBLKn  <= `K52_DR 1'b1;
      VBLKn  <= `K52_DR 1'b1;
      HSYNCn <= `K52_DR 1'b1;
      VSYNCn <= `K52_DR 1'b1;
    end else if (PE) begin
      HBLKn  <= `K52_DF ({1'b0, hnx} < HA);
      VBLKn  <= `K52_DF ({1'b0, vnx} < VA);
      HSYNCn <= `K52_DF !({1'b0, hnx} >= HSS && {1'b0, hnx} < HSE);
      VSYNCn <= `K52_DF !({1'b0, vnx} >= VSS && {1'b0, vnx} < VSE);
    end
  end

  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) begin
      IRQn <= `K52_DR 1'b1;
    end else if (irq_set) begin
      IRQn <= `K52_DF 1'b0;
    end else if (irq_clr) begin
      IRQn <= `K52_DF 1'b1;
    end
  end

endmodule

`undef K52_DC
`undef K52_DF
`undef K52_DR
